// File: rtl/agu_burst_sequencer_pkg.sv
// Shared types and defaults for the burst address sequencer: FSM states,
// default widths, descriptor layout and the round-robin pick helper.
package agu_pkg;

  localparam int AGU_ADDR_W = 64;
  localparam int AGU_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [AGU_ADDR_W-1:0] start;
    logic [AGU_ADDR_W-1:0] stride;
    logic [AGU_CNT_W-1:0]  count;
  } desc_t;

  // Index to grant among two requesters; ptr names the favoured one.
  // Only meaningful when at least one request bit is set.
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    logic pick;
    pick = req[ptr] ? ptr : ~ptr;
    return pick;
  endfunction

endpackage

// File: rtl/agu_burst_sequencer_if.sv
// Descriptor, address-stream and completion signals of the burst sequencer.
// master = sequencer side, slave = requesters / memory port side.
interface agu_burst_sequencer_if #(
  parameter int ADDR_W = agu_pkg::AGU_ADDR_W,
  parameter int CNT_W  = agu_pkg::AGU_CNT_W
);

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*ADDR_W-1:0] req_start;
  logic [2*ADDR_W-1:0] req_stride;
  logic [2*CNT_W-1:0]  req_count;
  logic                abort;

  logic                addr_valid;
  logic                addr_ready;
  logic [ADDR_W-1:0]   generated_address;
  logic                addr_last;
  logic                addr_owner;

  logic                done_valid;
  logic                done_owner;
  logic                done_aborted;

  modport master (
    input  req_valid, req_start, req_stride, req_count, abort, addr_ready,
    output req_ready, addr_valid, generated_address, addr_last, addr_owner,
           done_valid, done_owner, done_aborted
  );

  modport slave (
    output req_valid, req_start, req_stride, req_count, abort, addr_ready,
    input  req_ready, addr_valid, generated_address, addr_last, addr_owner,
           done_valid, done_owner, done_aborted
  );

endinterface

// File: rtl/agu_burst_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves past the winner only when
// a grant is actually issued (en high and a request present).
module rr_arbiter2
  import agu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic ptr_reg;
  logic ptr_next;
  logic any_req;

  assign any_req = |req;
  assign gnt_idx = rr_pick(req, ptr_reg);

  always_comb begin
    gnt      = 2'b00;
    ptr_next = ptr_reg;
    if (en && any_req) begin
      gnt[gnt_idx] = 1'b1;
      ptr_next     = ~gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/agu_burst_sequencer.sv
// Burst address sequencer: grants one of two descriptors, then steps the
// address once per accepted beat and reports burst completion.
module agu_burst_sequencer
  import agu_pkg::*;
#(
  parameter int ADDR_W = AGU_ADDR_W,
  parameter int CNT_W  = AGU_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  agu_burst_sequencer_if.master bus
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] stride_reg, stride_next;
  logic [CNT_W-1:0]  remaining_reg, remaining_next;
  logic              owner_reg, owner_next;
  logic              abort_reg, abort_next;

  logic [ADDR_W-1:0] start_arr  [2];
  logic [ADDR_W-1:0] stride_arr [2];
  logic [CNT_W-1:0]  count_arr  [2];

  logic [1:0] gnt;
  logic       gnt_idx;
  logic       arb_en;
  logic       abort_now;
  logic       last_beat;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign start_arr[gi]  = bus.req_start[gi*ADDR_W +: ADDR_W];
      assign stride_arr[gi] = bus.req_stride[gi*ADDR_W +: ADDR_W];
      assign count_arr[gi]  = bus.req_count[gi*CNT_W +: CNT_W];
    end
  endgenerate

  // Grants happen only in IDLE, so req_ready can never pulse mid-burst.
  assign arb_en = (state_reg == IDLE);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready         = gnt;
  assign bus.generated_address = addr_reg;
  assign bus.addr_owner        = owner_reg;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    stride_next    = stride_reg;
    remaining_next = remaining_reg;
    owner_next     = owner_reg;
    abort_next     = abort_reg;
    abort_now      = 1'b0;
    last_beat      = 1'b0;
    bus.addr_valid   = 1'b0;
    bus.addr_last    = 1'b0;
    bus.done_valid   = 1'b0;
    bus.done_owner   = 1'b0;
    bus.done_aborted = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|gnt) begin
          addr_next      = start_arr[gnt_idx];
          stride_next    = stride_arr[gnt_idx];
          remaining_next = count_arr[gnt_idx];
          owner_next     = gnt_idx;
          abort_next     = 1'b0;
          state_next     = (count_arr[gnt_idx] == '0) ? DONE : ISSUE;
        end
      end

      ISSUE: begin
        // A live abort marks the beat on offer as last in the same cycle.
        abort_now     = abort_reg | bus.abort;
        last_beat     = (remaining_reg == CNT_W'(1)) || abort_now;
        abort_next    = abort_now;
        bus.addr_valid = 1'b1;
        bus.addr_last  = last_beat;
        if (bus.addr_ready) begin
          addr_next      = addr_reg + stride_reg;
          remaining_next = remaining_reg - CNT_W'(1);
          if (last_beat) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        bus.done_valid   = 1'b1;
        bus.done_owner   = owner_reg;
        bus.done_aborted = abort_reg;
        state_next       = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      stride_reg    <= '0;
      remaining_reg <= '0;
      owner_reg     <= 1'b0;
      abort_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      stride_reg    <= stride_next;
      remaining_reg <= remaining_next;
      owner_reg     <= owner_next;
      abort_reg     <= abort_next;
    end
  end

endmodule

// File: tb/tb_agu_burst_sequencer.sv
// Directed scoreboard bench for agu_burst_sequencer: drivers queue expected
// grants, beats and completions; a negedge monitor pops and compares them.
module tb_agu_burst_sequencer;

  logic clk;
  logic rst;

  agu_burst_sequencer_if #(.ADDR_W(64), .CNT_W(16)) bus ();

  agu_burst_sequencer #(.ADDR_W(64), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic        last;
    logic        owner;
  } beat_t;

  typedef struct packed {
    logic owner;
    logic aborted;
  } done_t;

  beat_t exp_beats [$];
  done_t exp_dones [$];
  logic  exp_grants [$];

  int n_cmp = 0;
  int n_bad = 0;
  int hs_total = 0;

  logic        hold_pend = 1'b0;
  logic [63:0] hold_addr;
  logic        hold_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event expected none/other", nm);
  endtask

  task automatic push_beat(input logic [63:0] a, input logic l, input logic o);
    beat_t b;
    b.addr = a; b.last = l; b.owner = o;
    exp_beats.push_back(b);
  endtask

  task automatic push_done(input logic o, input logic ab);
    done_t d;
    d.owner = o; d.aborted = ab;
    exp_dones.push_back(d);
  endtask

  // Monitor: compares every grant, accepted beat and completion pulse.
  always @(negedge clk) begin
    if (hold_pend) begin
      chk("hold_valid", {63'd0, bus.addr_valid}, 64'd1);
      chk("hold_addr", bus.generated_address, hold_addr);
      chk("hold_last", {63'd0, bus.addr_last}, {63'd0, hold_last});
    end
    if (bus.req_ready == 2'b01 || bus.req_ready == 2'b10 || bus.req_ready == 2'b11) begin
      chk("ready_onehot", {63'd0, (bus.req_ready == 2'b11)}, 64'd0);
      if (exp_grants.size() == 0) begin
        fail_now("unexpected_grant");
      end else begin
        logic g;
        g = exp_grants.pop_front();
        chk("grant", {62'd0, bus.req_ready}, g ? 64'd2 : 64'd1);
        $display("grant  ready=%b", bus.req_ready);
      end
    end
    if (bus.addr_valid === 1'b1 && bus.addr_ready === 1'b1) begin
      hs_total++;
      if (exp_beats.size() == 0) begin
        fail_now("unexpected_beat");
      end else begin
        beat_t b;
        b = exp_beats.pop_front();
        chk("beat_addr", bus.generated_address, b.addr);
        chk("beat_last", {63'd0, bus.addr_last}, {63'd0, b.last});
        chk("beat_owner", {63'd0, bus.addr_owner}, {63'd0, b.owner});
        $display("beat   addr=0x%016h last=%0b owner=%0b", bus.generated_address,
                 bus.addr_last, bus.addr_owner);
      end
    end
    if (bus.done_valid === 1'b1) begin
      if (exp_dones.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        done_t d;
        d = exp_dones.pop_front();
        chk("done_owner", {63'd0, bus.done_owner}, {63'd0, d.owner});
        chk("done_aborted", {63'd0, bus.done_aborted}, {63'd0, d.aborted});
        $display("done   owner=%0b aborted=%0b", bus.done_owner, bus.done_aborted);
      end
    end
    hold_pend = (bus.addr_valid === 1'b1) && (bus.addr_ready === 1'b0) && (rst === 1'b0);
    hold_addr = bus.generated_address;
    hold_last = bus.addr_last;
  end

  // Presents one descriptor and returns one cycle after it was granted.
  task automatic send(input int i, input logic [63:0] s, input logic [63:0] st,
                      input logic [15:0] c);
    logic got;
    got = 1'b0;
    bus.req_start[i*64 +: 64]  = s;
    bus.req_stride[i*64 +: 64] = st;
    bus.req_count[i*16 +: 16]  = c;
    bus.req_valid[i]           = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) got = 1'b1;
    end
    if (!got) fail_now("grant_timeout");
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    logic empty;
    empty = 1'b0;
    for (int k = 0; k < 100 && !empty; k++) begin
      @(negedge clk);
      empty = (exp_beats.size() == 0) && (exp_dones.size() == 0) && (exp_grants.size() == 0);
    end
    if (!empty) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {62'd0, bus.req_ready}, 64'd0);
    chk({tag, "_addr_valid"}, {63'd0, bus.addr_valid}, 64'd0);
    chk({tag, "_gen_addr"}, bus.generated_address, 64'd0);
    chk({tag, "_addr_last"}, {63'd0, bus.addr_last}, 64'd0);
    chk({tag, "_addr_owner"}, {63'd0, bus.addr_owner}, 64'd0);
    chk({tag, "_done_valid"}, {63'd0, bus.done_valid}, 64'd0);
    chk({tag, "_done_owner"}, {63'd0, bus.done_owner}, 64'd0);
    chk({tag, "_done_aborted"}, {63'd0, bus.done_aborted}, 64'd0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
    n_cmp++;
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int hs_before;
    rst            = 1'b1;
    bus.req_valid  = 2'b00;
    bus.req_start  = '0;
    bus.req_stride = '0;
    bus.req_count  = '0;
    bus.abort      = 1'b0;
    bus.addr_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Both requesters always valid, one beat each: grants alternate 0,1,0,1.
    for (int k = 0; k < 2; k++) begin
      exp_grants.push_back(1'b0); push_beat(64'h2000, 1'b1, 1'b0); push_done(1'b0, 1'b0);
      exp_grants.push_back(1'b1); push_beat(64'h3000, 1'b1, 1'b1); push_done(1'b1, 1'b0);
    end
    bus.req_start  = {64'h3000, 64'h2000};
    bus.req_stride = {64'h4, 64'h4};
    bus.req_count  = {16'd1, 16'd1};
    bus.req_valid  = 2'b11;
    begin
      int grants;
      grants = 0;
      for (int k = 0; k < 100 && grants < 4; k++) begin
        @(negedge clk);
        if (bus.req_ready != 2'b00) grants++;
      end
      if (grants < 4) fail_now("alt_grant_timeout");
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
    end
    wait_idle();

    // Plain 4-beat burst from requester 0.
    exp_grants.push_back(1'b0);
    push_beat(64'h1000, 1'b0, 1'b0);
    push_beat(64'h1008, 1'b0, 1'b0);
    push_beat(64'h1010, 1'b0, 1'b0);
    push_beat(64'h1018, 1'b1, 1'b0);
    push_done(1'b0, 1'b0);
    send(0, 64'h1000, 64'h8, 16'd4);
    wait_idle();

    // Address wraps modulo 2^64.
    exp_grants.push_back(1'b1);
    push_beat(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1);
    push_beat(64'h0000_0000_0000_0008, 1'b1, 1'b1);
    push_done(1'b1, 1'b0);
    send(1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 16'd2);
    wait_idle();

    // Zero-beat descriptor: completion right after the grant, no beats.
    exp_grants.push_back(1'b1);
    push_done(1'b1, 1'b0);
    send(1, 64'h9000, 64'h4, 16'd0);
    @(negedge clk);
    chk("zero_cnt_done_valid", {63'd0, bus.done_valid}, 64'd1);
    chk("zero_cnt_addr_valid", {63'd0, bus.addr_valid}, 64'd0);
    wait_idle();

    // Backpressure for 3 cycles on beat 2, then abort while beat 3 is offered.
    hs_before = hs_total;
    exp_grants.push_back(1'b0);
    push_beat(64'h4000, 1'b0, 1'b0);
    push_beat(64'h4004, 1'b0, 1'b0);
    push_beat(64'h4008, 1'b1, 1'b0);
    push_done(1'b0, 1'b1);
    send(0, 64'h4000, 64'h4, 16'd8);
    @(posedge clk); #1; bus.addr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1; bus.addr_ready = 1'b0;
    @(posedge clk); #1; bus.addr_ready = 1'b1;
    @(posedge clk); #1; bus.abort = 1'b1;
    @(posedge clk); #1; bus.abort = 1'b0;
    wait_idle();
    chk("abort_handshakes", 64'(hs_total - hs_before), 64'd3);

    // Reset while beat 2 of a burst is on offer: burst vanishes, pointer clears.
    exp_grants.push_back(1'b0);
    push_beat(64'h5000, 1'b0, 1'b0);
    send(0, 64'h5000, 64'h1, 16'd4);
    @(posedge clk); #1;
    bus.addr_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.addr_ready = 1'b1;
    @(negedge clk);
    chk("midrst_no_done", {63'd0, bus.done_valid}, 64'd0);
    @(posedge clk); #1;

    exp_grants.push_back(1'b0);
    push_beat(64'h6000, 1'b1, 1'b0);
    push_done(1'b0, 1'b0);
    bus.req_start  = {64'h7000, 64'h6000};
    bus.req_count  = {16'd1, 16'd1};
    bus.req_valid  = 2'b11;
    begin
      logic got;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        if (bus.req_ready != 2'b00) got = 1'b1;
      end
      if (!got) fail_now("post_rst_grant_timeout");
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
    end
    wait_idle();
    repeat (3) @(posedge clk);

    chk("left_beats", 64'(exp_beats.size()), 64'd0);
    chk("left_dones", 64'(exp_dones.size()), 64'd0);
    chk("left_grants", 64'(exp_grants.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
